// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix size, key_code field positions and
// the emulator FSM state type.
package keypad_pkg;

  localparam int KP_ROWS     = 4;
  localparam int KP_COLS     = 4;
  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    BOUNCE_PRESS = 3'd1,
    HELD         = 3'd2,
    BOUNCE_REL   = 3'd3,
    GAP          = 3'd4
  } kpemu_state_t;

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-request handshake plus the scanner-facing row/column lines.
interface keypad_emulator_if import keypad_pkg::*; ();

  logic [3:0]         key_code;
  logic               press_req;
  logic               ready;
  logic               busy;
  logic               done;
  logic [KP_COLS-1:0] kpc;
  logic [KP_ROWS-1:0] kpr;

  modport master (output key_code, press_req, kpc, input ready, busy, done, kpr);
  modport slave  (input key_code, press_req, kpc, output ready, busy, done, kpr);

endinterface

// File: rtl/keypad_emulator.sv
// Emulates one matrix-keypad key press with contact bounce, hold and release gap.
// Define KPEMU_BOUNCE_EN to model bounce bursts; otherwise bounce states last one cycle.
module keypad_emulator import keypad_pkg::*; #(
  parameter int unsigned HOLD_CYCLES    = 2500000,
  parameter int unsigned BOUNCE_CYCLES  = 50000,
  parameter int unsigned BOUNCE_TOGGLES = 6,
  parameter int unsigned GAP_CYCLES     = 500000
) (
  input  logic clk,
  input  logic reset_n,
  keypad_emulator_if.slave kp
);

  kpemu_state_t       state;
  logic [31:0]        cnt;
  logic               closed;
  logic [1:0]         row_q, col_q;
  logic [KP_ROWS-1:0] kpr_q;
  logic               hold_end, gap_end;

  assign hold_end = (state == HELD) && (cnt == 32'(HOLD_CYCLES - 1));
  assign gap_end  = (state == GAP)  && (cnt == 32'(GAP_CYCLES - 1));

`ifdef KPEMU_BOUNCE_EN
  localparam int PW = (BOUNCE_TOGGLES > 2) ? $clog2(BOUNCE_TOGGLES) : 1;
  logic [PW-1:0] phase;
  logic          ph_end;
  assign ph_end = (cnt == 32'(BOUNCE_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      closed <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
`ifdef KPEMU_BOUNCE_EN
      phase  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (kp.press_req) begin
          row_q  <= kp.key_code[KEY_ROW_MSB:KEY_ROW_LSB];
          col_q  <= kp.key_code[KEY_COL_MSB:KEY_COL_LSB];
          state  <= BOUNCE_PRESS;
          closed <= 1'b1;
          cnt    <= '0;
`ifdef KPEMU_BOUNCE_EN
          phase  <= '0;
`endif
        end
        BOUNCE_PRESS, BOUNCE_REL: begin
`ifdef KPEMU_BOUNCE_EN
          // even toggle count leaves closed at the following state's level
          if (ph_end) begin
            cnt    <= '0;
            closed <= ~closed;
            if (phase == PW'(BOUNCE_TOGGLES - 1)) begin
              phase <= '0;
              state <= (state == BOUNCE_PRESS) ? HELD : GAP;
            end else begin
              phase <= phase + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          cnt   <= '0;
          state <= (state == BOUNCE_PRESS) ? HELD : GAP;
`endif
        end
        HELD: if (hold_end) begin
          state  <= BOUNCE_REL;
          closed <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GAP: if (gap_end) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          closed <= 1'b0;
        end
      endcase
    end
  end

  // a row is pulled low only while the selected column is driven low
  for (genvar r = 0; r < KP_ROWS; r++) begin : g_row
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) kpr_q[r] <= 1'b1;
      else          kpr_q[r] <= ~((row_q == 2'(r)) && closed && !kp.kpc[col_q]);
    end
  end

  assign kp.ready = (state == IDLE);
  assign kp.busy  = (state != IDLE);
  assign kp.done  = gap_end;
  assign kp.kpr   = kpr_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator with small timing parameters.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 20, BOUNCE = 3, TOGGLES = 4, GAP = 5;
`ifdef KPEMU_BOUNCE_EN
  localparam int PRE = TOGGLES * BOUNCE;
`else
  localparam int PRE = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  keypad_emulator_if kp();

  keypad_emulator #(.HOLD_CYCLES(HOLD), .BOUNCE_CYCLES(BOUNCE),
                    .BOUNCE_TOGGLES(TOGGLES), .GAP_CYCLES(GAP))
    dut (.clk(clk), .reset_n(reset_n), .kp(kp));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] kpr;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] kpr_of(input logic c, input logic [3:0] key, input logic [3:0] kpc_v);
    logic [3:0] v;
    v = 4'hF;
    if (c && !kpc_v[key[1:0]]) v[key[3:2]] = 1'b0;
    return v;
  endfunction

  // expected contact timeline, one entry per busy cycle after acceptance
  task automatic push_press(input logic [3:0] key, input logic [3:0] kpc_v);
    logic c[$];
    logic prev;
    obs_t e;
`ifdef KPEMU_BOUNCE_EN
    for (int p = 0; p < TOGGLES; p++) repeat (BOUNCE) c.push_back(p % 2 == 0);
`else
    c.push_back(1'b1);
`endif
    repeat (HOLD) c.push_back(1'b1);
`ifdef KPEMU_BOUNCE_EN
    for (int p = 0; p < TOGGLES; p++) repeat (BOUNCE) c.push_back(p % 2 == 1);
`else
    c.push_back(1'b0);
`endif
    repeat (GAP) c.push_back(1'b0);
    prev = 1'b0;
    for (int i = 0; i < c.size(); i++) begin
      e.kpr = kpr_of(prev, key, kpc_v);
      e.busy = 1'b1;
      e.done = (i == c.size() - 1);
      e.ready = 1'b0;
      exp_q.push_back(e);
      prev = c[i];
    end
    e.kpr = kpr_of(prev, key, kpc_v);
    e.busy = 1'b0;
    e.done = 1'b0;
    e.ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic press(input string tag, input logic [3:0] key, input logic [3:0] kpc_v,
                       input bit keep_req, input bit poke);
    obs_t e;
    int   i;
    kp.kpc = kpc_v;
    kp.key_code = key;
    kp.press_req = 1'b1;
    push_press(key, kpc_v);
    @(posedge clk); #1;
    if (!keep_req) kp.press_req = 1'b0;
    kp.key_code = ~key;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s kpr@%0d", tag, i), kp.kpr, e.kpr);
      chk($sformatf("%s busy@%0d", tag, i), kp.busy, e.busy);
      chk($sformatf("%s done@%0d", tag, i), kp.done, e.done);
      chk($sformatf("%s ready@%0d", tag, i), kp.ready, e.ready);
      if (poke && i == 4) kp.press_req = 1'b1;
      if (poke && i == 7) kp.press_req = 1'b0;
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int seen_done;
    logic [3:0] kv [5];
    kv = '{4'h0, 4'h5, 4'hA, 4'hE, 4'h7};
    kp.key_code = 4'h0;
    kp.press_req = 1'b0;
    kp.kpc = 4'hF;

    repeat (2) @(negedge clk);
    chk("rst kpr", kp.kpr, 4'hF);
    chk("rst busy", kp.busy, 1'b0);
    chk("rst done", kp.done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-rst ready", kp.ready, 1'b1);
    chk("post-rst busy", kp.busy, 1'b0);

    foreach (kv[j]) begin
      kp.kpc = kv[j];
      @(negedge clk);
      chk($sformatf("idle kpr kpc=%h", kv[j]), kp.kpr, 4'hF);
    end

    press("p0110", 4'b0110, 4'b1011, 1'b0, 1'b1);
    @(negedge clk);
    chk("no queued press", kp.busy, 1'b0);
    press("wrongcol", 4'b0110, 4'b1101, 1'b0, 1'b0);
    press("multizero", 4'b1111, 4'b0000, 1'b0, 1'b0);
    press("held1", 4'b1001, 4'b1101, 1'b1, 1'b0);
    press("held2", 4'b1001, 4'b1101, 1'b0, 1'b0);
    @(negedge clk);
    chk("after held busy", kp.busy, 1'b0);

    kp.kpc = 4'b1011;
    kp.key_code = 4'b0110;
    kp.press_req = 1'b1;
    @(posedge clk); #1;
    kp.press_req = 1'b0;
    repeat (PRE + 5) @(negedge clk);
    chk("held kpr", kp.kpr, 4'b1101);
    chk("held busy", kp.busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort kpr", kp.kpr, 4'hF);
    chk("abort busy", kp.busy, 1'b0);
    chk("abort done", kp.done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort ready", kp.ready, 1'b1);
    seen_done = 0;
    repeat (HOLD + GAP + 2 * PRE + 4) begin
      @(negedge clk);
      if (kp.done || kp.busy) seen_done++;
    end
    chk("abort no done", seen_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
